// File: rtl/mem_arbiter.sv
// Shares one single-port memory between the IF and DM ports of the MIPS core.
// Define MEM_ARBITER_RR_EN to alternate grants on contention instead of fixed DM priority.
module mem_arbiter #(
  parameter int AW  = 32,
  parameter int DW  = 32,
  parameter int LAT = 2
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          if_req,
  input  logic [AW-1:0] if_addr,
  output logic          if_ready,
  output logic [DW-1:0] if_rdata,
  input  logic          dm_req,
  input  logic          dm_we,
  input  logic [AW-1:0] dm_addr,
  input  logic [DW-1:0] dm_wdata,
  output logic          dm_ready,
  output logic [DW-1:0] dm_rdata,
  output logic          stall_f,
  output logic          stall_m,
  output logic          mem_en,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata
);

  localparam int CW = $clog2(LAT) + 1;
  localparam logic PORT_IF = 1'b0;
  localparam logic PORT_DM = 1'b1;

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t        state;
  logic [CW-1:0] cnt;
  logic [AW-1:0] addr_q;
  logic [DW-1:0] wdata_q;
  logic [DW-1:0] rdata_q;
  logic          we_q;
  logic          gnt_q;
  logic          en_q;
  logic          if_rdy_q;
  logic          dm_rdy_q;
  logic          dm_wins;

`ifdef MEM_ARBITER_RR_EN
  logic last_q;
  // On contention the port that did not win last time goes first.
  assign dm_wins = dm_req & (~if_req | (last_q == PORT_IF));
`else
  assign dm_wins = dm_req;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      cnt      <= '0;
      addr_q   <= '0;
      wdata_q  <= '0;
      rdata_q  <= '0;
      we_q     <= 1'b0;
      gnt_q    <= PORT_IF;
      en_q     <= 1'b0;
      if_rdy_q <= 1'b0;
      dm_rdy_q <= 1'b0;
`ifdef MEM_ARBITER_RR_EN
      last_q   <= PORT_IF;
`endif
    end else begin
      if_rdy_q <= 1'b0;
      dm_rdy_q <= 1'b0;
      case (state)
        IDLE: begin
          if (if_req | dm_req) begin
            gnt_q   <= dm_wins ? PORT_DM : PORT_IF;
            addr_q  <= dm_wins ? dm_addr : if_addr;
            wdata_q <= dm_wins ? dm_wdata : '0;
            we_q    <= dm_wins & dm_we;
            en_q    <= 1'b1;
            cnt     <= CW'(LAT - 1);
            state   <= BUSY;
`ifdef MEM_ARBITER_RR_EN
            last_q  <= dm_wins ? PORT_DM : PORT_IF;
`endif
          end
        end
        BUSY: begin
          if (cnt == '0) begin
            if (!we_q) rdata_q <= mem_rdata;
            en_q     <= 1'b0;
            if_rdy_q <= (gnt_q == PORT_IF);
            dm_rdy_q <= (gnt_q == PORT_DM);
            state    <= DONE;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  assign mem_en    = en_q;
  assign mem_we    = en_q & we_q;
  assign mem_addr  = addr_q;
  assign mem_wdata = wdata_q;
  assign if_ready  = if_rdy_q;
  assign dm_ready  = dm_rdy_q;
  assign if_rdata  = rdata_q;
  assign dm_rdata  = rdata_q;

  // Stalls follow the live request so the pipeline freezes from the first req cycle.
  assign stall_f = ~reset & if_req & ~if_rdy_q;
  assign stall_m = ~reset & dm_req & ~dm_rdy_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Randomized bench for mem_arbiter against a transaction-level timing and memory model.
module tb_mem_arbiter;
  localparam int AW  = 32;
  localparam int DW  = 32;
  localparam int LAT = 2;
`ifdef MEM_ARBITER_RR_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          if_req = 1'b0;
  logic [AW-1:0] if_addr = '0;
  logic          if_ready;
  logic [DW-1:0] if_rdata;
  logic          dm_req = 1'b0;
  logic          dm_we = 1'b0;
  logic [AW-1:0] dm_addr = '0;
  logic [DW-1:0] dm_wdata = '0;
  logic          dm_ready;
  logic [DW-1:0] dm_rdata;
  logic          stall_f, stall_m;
  logic          mem_en, mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata;

  mem_arbiter #(.AW(AW), .DW(DW), .LAT(LAT)) dut (
    .clk(clk), .reset(reset),
    .if_req(if_req), .if_addr(if_addr), .if_ready(if_ready), .if_rdata(if_rdata),
    .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
    .dm_ready(dm_ready), .dm_rdata(dm_rdata),
    .stall_f(stall_f), .stall_m(stall_m),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  // Memory device seen by the DUT, and the reference contents the model expects.
  logic [DW-1:0] dev_mem [256];
  logic [DW-1:0] ref_mem [256];
  assign mem_rdata = dev_mem[mem_addr[9:2]];

  int n_cmp = 0;
  int n_mis = 0;

  // Model state: one transaction at a time, granted in cycle st.
  int            cyc = 0;
  int            st = 0;
  int            n_txn = 0;
  bit            busy = 1'b0;
  bit            w_dm = 1'b0;
  bit            last_dm = 1'b0;
  bit            t_we = 1'b0;
  logic [AW-1:0] t_addr = '0;
  logic [DW-1:0] t_wdata = '0;
  logic [DW-1:0] exp_rdata = '0;
  bit            if_done = 1'b0, dm_done = 1'b0;

  // Directed requests queued for the next drive slot.
  bit            q_if = 1'b0, q_dm = 1'b0, q_dm_we = 1'b0;
  logic [AW-1:0] q_if_addr = '0, q_dm_addr = '0;
  logic [DW-1:0] q_dm_wdata = '0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_mis++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic drive(input int pct);
    if (if_done) begin if_req = 1'b0; if_done = 1'b0; end
    if (dm_done) begin dm_req = 1'b0; dm_done = 1'b0; end
    if (!if_req && q_if) begin
      if_req = 1'b1; if_addr = q_if_addr; q_if = 1'b0;
    end else if (!if_req && $urandom_range(0, 99) < pct) begin
      if_req = 1'b1; if_addr = {22'd0, 8'($urandom_range(0, 255)), 2'b00};
    end
    if (!dm_req && q_dm) begin
      dm_req = 1'b1; dm_we = q_dm_we; dm_addr = q_dm_addr; dm_wdata = q_dm_wdata; q_dm = 1'b0;
    end else if (!dm_req && $urandom_range(0, 99) < pct) begin
      dm_req = 1'b1; dm_we = 1'($urandom_range(0, 1));
      dm_addr = {22'd0, 8'($urandom_range(0, 255)), 2'b00}; dm_wdata = $urandom;
    end
  endtask

  task automatic step(input int pct);
    bit en, rdy;
    @(posedge clk); #1;
    drive(pct);
    #1;
    en  = busy && (cyc >= st + 1) && (cyc <= st + LAT);
    rdy = busy && (cyc == st + LAT + 1);
    if (rdy && !t_we) exp_rdata = ref_mem[t_addr[9:2]];
    check_eq("mem_en", 32'(mem_en), 32'(en));
    check_eq("mem_we", 32'(mem_we), 32'(en & t_we));
    if (en) begin
      check_eq("mem_addr", mem_addr, t_addr);
      if (t_we) check_eq("mem_wdata", mem_wdata, t_wdata);
    end
    check_eq("if_ready", 32'(if_ready), 32'(rdy & !w_dm));
    check_eq("dm_ready", 32'(dm_ready), 32'(rdy & w_dm));
    check_eq("if_rdata", if_rdata, exp_rdata);
    check_eq("dm_rdata", dm_rdata, exp_rdata);
    check_eq("stall_f", 32'(stall_f), 32'(if_req & !(rdy & !w_dm)));
    check_eq("stall_m", 32'(stall_m), 32'(dm_req & !(rdy & w_dm)));
    if (mem_en && mem_we) dev_mem[mem_addr[9:2]] = mem_wdata;
    if (!busy && (if_req || dm_req)) begin
      w_dm    = dm_req && (!if_req || !RR || !last_dm);
      last_dm = w_dm;
      busy    = 1'b1;
      st      = cyc;
      t_addr  = w_dm ? dm_addr : if_addr;
      t_we    = w_dm && dm_we;
      t_wdata = dm_wdata;
      if (t_we) ref_mem[t_addr[9:2]] = t_wdata;
    end else if (rdy) begin
      busy = 1'b0;
      n_txn++;
      $display("txn %0d: port=%s we=%0d addr=%h data=%h cycle=%0d", n_txn, w_dm ? "DM" : "IF",
               t_we, t_addr, t_we ? t_wdata : exp_rdata, cyc);
      if (w_dm) dm_done = 1'b1; else if_done = 1'b1;
    end
    cyc++;
  endtask

  task automatic run(input int n, input int pct);
    for (int i = 0; i < n; i++) step(pct);
  endtask

  task automatic apply_reset();
    reset = 1'b1;
    if_req = 1'b0; dm_req = 1'b0; if_done = 1'b0; dm_done = 1'b0;
    busy = 1'b0; last_dm = 1'b0; exp_rdata = '0; cyc = 0;
    #1;
    check_eq("rst_mem_en", 32'(mem_en), 32'd0);
    check_eq("rst_if_ready", 32'(if_ready), 32'd0);
    check_eq("rst_dm_ready", 32'(dm_ready), 32'd0);
    check_eq("rst_rdata", if_rdata, 32'd0);
    check_eq("rst_mem_addr", mem_addr, 32'd0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
  endtask

  initial begin
    for (int i = 0; i < 256; i++) begin
      dev_mem[i] = $urandom;
      ref_mem[i] = dev_mem[i];
    end
    dev_mem[16]  = 32'h8C010004; ref_mem[16]  = 32'h8C010004;
    dev_mem[192] = 32'h12345678; ref_mem[192] = 32'h12345678;
    apply_reset();

    // Single fetch of 0x40.
    q_if = 1'b1; q_if_addr = 32'h40;
    run(6, 0);
    // Contention: DM read of 0x100 and a fetch in the same cycle.
    q_if = 1'b1; q_if_addr = 32'h44;
    q_dm = 1'b1; q_dm_we = 1'b0; q_dm_addr = 32'h100;
    run(10, 0);
    // Data write; read data must hold.
    q_dm = 1'b1; q_dm_we = 1'b1; q_dm_addr = 32'h200; q_dm_wdata = 32'hDEADBEEF;
    run(6, 0);
    // DM read of 0x300.
    q_dm = 1'b1; q_dm_we = 1'b0; q_dm_addr = 32'h300;
    run(6, 0);

    // Reset during the first BUSY cycle of a fetch.
    q_if = 1'b1; q_if_addr = 32'h48;
    for (int k = 0; k < 10 && !(busy && cyc == st + 1); k++) step(0);
    check_eq("rst_setup_busy", 32'(busy), 32'd1);
    @(posedge clk); #2;
    check_eq("pre_rst_mem_en", 32'(mem_en), 32'd1);
    reset = 1'b1; #1;
    check_eq("midrst_mem_en", 32'(mem_en), 32'd0);
    check_eq("midrst_mem_we", 32'(mem_we), 32'd0);
    check_eq("midrst_stall_f", 32'(stall_f), 32'd0);
    apply_reset();
    q_if = 1'b1; q_if_addr = 32'h4C;
    run(6, 0);

    // Saturated requests exercise the contention policy, then mixed random traffic.
    run(200, 100);
    run(3000, 30);
    run(LAT + 4, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Sequences a single shared single-port memory between the instruction-fetch port (IF) and the data-memory port (DM) of the pipelined MIPS core.
- Latches the winning request, holds the memory bus stable for LAT wait cycles, captures read data and pulses a one-cycle ready to the granted requester.
- Produces per-port stall outputs that drive the enable and clear inputs of the pipeline registers.

Parameters:
- AW, 32, address width.
- DW, 32, data width.
- LAT, 2, memory access cycles per transfer; legal range 1..16.

Ports:
- clk  in  1  clock.
- reset  in  1  asynchronous, active-high reset.
- if_req  in  1  fetch request; held until if_ready.
- if_addr  in  AW  fetch address.
- if_ready  out  1  one-cycle completion pulse for IF.
- if_rdata  out  DW  fetched word; valid while if_ready=1.
- dm_req  in  1  data request; held until dm_ready.
- dm_we  in  1  1 = write, 0 = read.
- dm_addr  in  AW  data address.
- dm_wdata  in  DW  write data.
- dm_ready  out  1  one-cycle completion pulse for DM.
- dm_rdata  out  DW  read data; valid while dm_ready=1.
- stall_f  out  1  IF waiting: if_req & ~if_ready.
- stall_m  out  1  DM waiting: dm_req & ~dm_ready.
- mem_en  out  1  memory access active.
- mem_we  out  1  memory write strobe.
- mem_addr  out  AW  memory address.
- mem_wdata  out  DW  memory write data.
- mem_rdata  in  DW  memory read data; valid on the final access cycle.

Behaviour:
- Clock and reset: reset is asynchronous and active-high; clk is the only clock.
- Reset values: state=IDLE; addr_q, wdata_q and rdata_q = 0; we_q=0; gnt_q=IF; cnt=0; last_q=IF.
- Outputs during reset: all outputs 0.
- FSM state IDLE:
  - mem_en=0.
  - If any request is pending, latch the winner's addr, wdata and we into addr_q, wdata_q and we_q.
  - Set gnt_q to the winner, cnt<=LAT-1, and go to BUSY.
  - With no request pending, stay in IDLE.
- FSM state BUSY:
  - mem_en=1; mem_addr=addr_q; mem_we=we_q; mem_wdata=wdata_q. These are registered and stable for all LAT cycles.
  - If cnt==0: when we_q=0, rdata_q<=mem_rdata; go to DONE. Otherwise cnt<=cnt-1.
- FSM state DONE:
  - mem_en=0.
  - Assert the ready output of the gnt_q port for exactly one cycle.
  - Always return to IDLE, with no back-to-back bypass.
- Latency: a request first seen in IDLE at cycle 0 occupies BUSY in cycles 1..LAT and sees ready in cycle LAT+1. Throughput is one transfer per LAT+2 cycles.
- Read data: if_rdata = dm_rdata = rdata_q. rdata_q is unchanged on writes and holds its value between transfers.
- Default priority: fixed, DM beats IF when both request in the same IDLE cycle. The older instruction must complete, which avoids deadlock.
- Requester handshake: the requester samples ready at the clock edge. A req still high in the DONE cycle is not treated as a new request. The next request is any req high in the following IDLE cycle.
- Req dropped during BUSY: illegal, but the access completes and ready still pulses.
- stall_f and stall_m: combinational. They are high from the first req cycle through the cycle before ready, so they cover the IDLE, BUSY and DONE-minus-ready cycles.
- Reset mid-access: the FSM returns to IDLE immediately. mem_en and mem_we drop asynchronously, the access is abandoned, and no ready is issued.
- LAT=1: BUSY lasts one cycle and cnt is effectively unused.
- cnt width: $clog2(LAT)+1 bits.

Optional Feature:
- Macro: MEM_ARBITER_RR_EN.
- When defined:
  - A last_q register records the last granted port, updated on every IDLE→BUSY transition; reset value IF.
  - When both ports request in IDLE, the port not equal to last_q wins.
  - Single requests are unaffected.
- When undefined: fixed DM priority; last_q is absent.

Test Plan:
- Single fetch, LAT=2:
  - Stimulus: if_req=1, if_addr=0x00000040 at cycle 0; memory returns 0x8C010004.
  - Required: mem_en=1 with mem_addr=0x40 in cycles 1-2; if_ready=1 and if_rdata=0x8C010004 in cycle 3; stall_f=1 in cycles 0-2.
- Contention, LAT=2, macro off:
  - Stimulus: if_req and dm_req (read, 0x100) both high at cycle 0.
  - Required: mem_addr=0x100 in cycles 1-2; dm_ready in cycle 3; IF access in BUSY cycles 5-6; if_ready in cycle 7; stall_f high in cycles 0-6.
- Data write:
  - Stimulus: dm_we=1, dm_addr=0x200, dm_wdata=0xDEADBEEF.
  - Required: mem_we=1 and mem_wdata=0xDEADBEEF in cycles 1-2; dm_ready in cycle 3; rdata_q keeps its prior value.
- Reset mid-BUSY:
  - Stimulus: reset pulsed in cycle 1 of a fetch.
  - Required: mem_en=0 the same cycle; no if_ready; a fresh if_req after reset completes in LAT+1 cycles.
- Round-robin, MEM_ARBITER_RR_EN:
  - Stimulus: both ports re-request continuously.
  - Required: grant order DM, IF, DM, IF.
  - Without the macro: DM only while dm_req is held.
- LAT=1 build:
  - Stimulus: single DM read of 0x300 returning 0x12345678.
  - Required: mem_en in cycle 1 only; dm_ready=1 and dm_rdata=0x12345678 in cycle 2.
